replacement_way_select: RTL and testbench



---
 rtl/replacement_way_select_pkg.sv | 29 ++
 rtl/replacement_way_select_plru_tree_update.sv | 53 +++++
 rtl/replacement_way_select.sv | 133 +++++++++++++
 tb/tb_replacement_way_select.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/replacement_way_select_pkg.sv
// Shared cache helpers: policy encodings, constant log2 and one-hot encoding
// used by the replacement logic.
package replacement_way_select_pkg;

  localparam int POLICY_PLRU = 0;
  localparam int POLICY_RR   = 1;

  // Widest one-hot vector the encode helper accepts.
  localparam int MAX_WAYS = 64;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int onehot_to_bin(input logic [MAX_WAYS-1:0] onehot);
    int r;
    r = 0;
    for (int i = 0; i < MAX_WAYS; i++) begin
      if (onehot[i]) r = r | i;
    end
    return r;
  endfunction

endpackage

// File: rtl/replacement_way_select_plru_tree_update.sv
// Combinational tree-PLRU helper: victim walk of the current tree and the
// tree after touching one way (an all-zero way leaves the tree unchanged).
module plru_tree_update
  import replacement_way_select_pkg::*;
#(
  parameter int NUMBER_OF_WAYS = 4
) (
  input  logic [NUMBER_OF_WAYS-2:0] tree_in,
  input  logic [NUMBER_OF_WAYS-1:0] way_onehot,
  output logic [NUMBER_OF_WAYS-2:0] tree_out,
  output logic [NUMBER_OF_WAYS-1:0] victim
);

  localparam int LEVELS = clog2_f(NUMBER_OF_WAYS);

  always_comb begin : victim_walk
    int   node;
    logic dir;
    node   = 0;
    dir    = 1'b0;
    victim = '0;
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      for (int k = 0; k < NUMBER_OF_WAYS - 1; k++) begin
        if (k == node) dir = tree_in[k];
      end
      node = 2 * node + 1 + int'(dir);
    end
    // Leaves are numbered after the N-1 internal nodes.
    for (int j = 0; j < NUMBER_OF_WAYS; j++) begin
      if (j == node - (NUMBER_OF_WAYS - 1)) victim[j] = 1'b1;
    end
  end

  always_comb begin : touch_walk
    int node;
    int way;
    int dir;
    tree_out = tree_in;
    node     = 0;
    dir      = 0;
    way      = onehot_to_bin(MAX_WAYS'(way_onehot));
    if (way_onehot != '0) begin
      for (int lvl = 0; lvl < LEVELS; lvl++) begin
        dir = (way >> (LEVELS - 1 - lvl)) & 1;
        for (int k = 0; k < NUMBER_OF_WAYS - 1; k++) begin
          if (k == node) tree_out[k] = (dir == 0);
        end
        node = 2 * node + 1 + dir;
      end
    end
  end

endmodule

// File: rtl/replacement_way_select.sv
// Registered per-set way allocator: lowest empty way first, otherwise a
// tree-PLRU or round-robin victim, with replacement state kept per set.
module replacement_way_select
  import replacement_way_select_pkg::*;
#(
  parameter int NUMBER_OF_WAYS = 4,
  parameter int INDEX_BITS     = 6,
  parameter int POLICY         = 0
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              req_valid,
  input  logic [INDEX_BITS-1:0]             req_index,
  input  logic [NUMBER_OF_WAYS-1:0]         ways_in_use,
  input  logic                              access_valid,
  input  logic [INDEX_BITS-1:0]             access_index,
  input  logic [NUMBER_OF_WAYS-1:0]         access_way,
  output logic                              resp_valid,
  output logic [NUMBER_OF_WAYS-1:0]         resp_way,
  output logic [clog2_f(NUMBER_OF_WAYS)-1:0] resp_way_encoded,
  output logic                              resp_was_empty
);

  localparam int WAY_BITS = clog2_f(NUMBER_OF_WAYS);
  localparam int SETS     = 2 ** INDEX_BITS;

  logic [NUMBER_OF_WAYS-2:0] plru_q [SETS];
  logic [NUMBER_OF_WAYS-2:0] plru_d [SETS];
  logic [WAY_BITS-1:0]       rr_q   [SETS];
  logic [WAY_BITS-1:0]       rr_d   [SETS];

  logic                      resp_valid_q, resp_valid_d;
  logic [NUMBER_OF_WAYS-1:0] resp_way_q, resp_way_d;
  logic [WAY_BITS-1:0]       resp_enc_q, resp_enc_d;
  logic                      resp_empty_q, resp_empty_d;

  logic [NUMBER_OF_WAYS-2:0] req_tree, acc_tree, acc_tree_next;
  logic [NUMBER_OF_WAYS-2:0] alloc_tree_in, alloc_tree_next;
  logic [NUMBER_OF_WAYS-1:0] acc_way_gated, acc_victim, alloc_victim;
  logic [NUMBER_OF_WAYS-1:0] plru_victim, rr_victim;
  logic [NUMBER_OF_WAYS-1:0] free_ways, empty_oh, chosen_way;
  logic                      set_full, same_set;

  assign req_tree      = plru_q[req_index];
  assign acc_tree      = plru_q[access_index];
  assign same_set      = (access_index == req_index);
  assign acc_way_gated = access_valid ? access_way : '0;

  // On a shared set the allocation touch is layered on top of the access
  // touch, while the victim still comes from the untouched tree; the access
  // instance sees exactly that tree when the indices match.
  assign alloc_tree_in = same_set ? acc_tree_next : req_tree;
  assign plru_victim   = same_set ? acc_victim : alloc_victim;

  plru_tree_update #(.NUMBER_OF_WAYS(NUMBER_OF_WAYS)) u_access_update (
    .tree_in    (acc_tree),
    .way_onehot (acc_way_gated),
    .tree_out   (acc_tree_next),
    .victim     (acc_victim)
  );

  plru_tree_update #(.NUMBER_OF_WAYS(NUMBER_OF_WAYS)) u_alloc_update (
    .tree_in    (alloc_tree_in),
    .way_onehot (chosen_way),
    .tree_out   (alloc_tree_next),
    .victim     (alloc_victim)
  );

  assign free_ways = ~ways_in_use;
  assign empty_oh  = free_ways & (ways_in_use + NUMBER_OF_WAYS'(1));
  assign set_full  = (free_ways == '0);

  always_comb begin
    rr_victim = '0;
    for (int j = 0; j < NUMBER_OF_WAYS; j++) begin
      rr_victim[j] = (rr_q[req_index] == WAY_BITS'(j));
    end
  end

  always_comb begin
    chosen_way = empty_oh;
    if (set_full) chosen_way = (POLICY == POLICY_RR) ? rr_victim : plru_victim;
  end

  always_comb begin
    plru_d = plru_q;
    rr_d   = rr_q;
    if (POLICY == POLICY_PLRU) begin
      if (access_valid) plru_d[access_index] = acc_tree_next;
      if (req_valid)    plru_d[req_index]    = alloc_tree_next;
    end else if (req_valid && set_full) begin
      rr_d[req_index] = rr_q[req_index] + WAY_BITS'(1);
    end
  end

  always_comb begin
    resp_valid_d = req_valid;
    resp_way_d   = resp_way_q;
    resp_enc_d   = resp_enc_q;
    resp_empty_d = resp_empty_q;
    if (req_valid) begin
      resp_way_d   = chosen_way;
      resp_enc_d   = WAY_BITS'(onehot_to_bin(MAX_WAYS'(chosen_way)));
      resp_empty_d = ~set_full;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_way_q   <= '0;
      resp_enc_q   <= '0;
      resp_empty_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
        rr_q[s]   <= '0;
      end
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_way_q   <= resp_way_d;
      resp_enc_q   <= resp_enc_d;
      resp_empty_q <= resp_empty_d;
      plru_q       <= plru_d;
      rr_q         <= rr_d;
    end
  end

  assign resp_valid       = resp_valid_q;
  assign resp_way         = resp_way_q;
  assign resp_way_encoded = resp_enc_q;
  assign resp_was_empty   = resp_empty_q;

endmodule

// File: tb/tb_replacement_way_select.sv
// Drives a PLRU and a round-robin instance with directed then random traffic
// and compares both against a per-set behavioural model every cycle.
module tb_replacement_way_select;

  localparam int N    = 4;
  localparam int IB   = 6;
  localparam int SETS = 64;
  localparam int L    = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [IB-1:0] req_index;
  logic [N-1:0]  ways_in_use;
  logic          access_valid;
  logic [IB-1:0] access_index;
  logic [N-1:0]  access_way;

  logic          p_valid, r_valid, p_empty, r_empty;
  logic [N-1:0]  p_way, r_way;
  logic [L-1:0]  p_enc, r_enc;

  replacement_way_select #(.NUMBER_OF_WAYS(N), .INDEX_BITS(IB), .POLICY(0)) dut_plru (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_index(req_index),
    .ways_in_use(ways_in_use), .access_valid(access_valid), .access_index(access_index),
    .access_way(access_way), .resp_valid(p_valid), .resp_way(p_way),
    .resp_way_encoded(p_enc), .resp_was_empty(p_empty)
  );

  replacement_way_select #(.NUMBER_OF_WAYS(N), .INDEX_BITS(IB), .POLICY(1)) dut_rr (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_index(req_index),
    .ways_in_use(ways_in_use), .access_valid(access_valid), .access_index(access_index),
    .access_way(access_way), .resp_valid(r_valid), .resp_way(r_way),
    .resp_way_encoded(r_enc), .resp_was_empty(r_empty)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  logic run_cmp = 1'b0;

  // Model state: PLRU tree bits per set (node n children 2n+1, 2n+2), RR pointer per set.
  int plru_bits [SETS][N-1];
  int rr_ptr    [SETS];

  logic         exp_valid;
  logic [N-1:0] exp_way_p, exp_way_r;
  logic [L-1:0] exp_enc_p, exp_enc_r;
  logic         exp_empty;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      rr_ptr[s] = 0;
      for (int n = 0; n < N - 1; n++) plru_bits[s][n] = 0;
    end
    exp_valid = 1'b0; exp_way_p = '0; exp_way_r = '0;
    exp_enc_p = '0; exp_enc_r = '0; exp_empty = 1'b0;
  endtask

  function automatic int model_victim(input int s);
    int node;
    node = 0;
    for (int lvl = 0; lvl < L; lvl++) node = 2 * node + 1 + plru_bits[s][node];
    return node - (N - 1);
  endfunction

  task automatic model_touch(input int s, input int w);
    int node;
    int dir;
    node = 0;
    for (int lvl = 0; lvl < L; lvl++) begin
      dir = (w >> (L - 1 - lvl)) & 1;
      plru_bits[s][node] = 1 - dir;
      node = 2 * node + 1 + dir;
    end
  endtask

  // One clock edge of the reference behaviour, using the inputs present at that edge.
  task automatic model_step();
    int free_idx, wp, wr, ri, aw;
    free_idx = -1; wp = 0; wr = 0; aw = -1;
    ri = int'(req_index);
    for (int i = 0; i < N; i++) if (!ways_in_use[i] && free_idx < 0) free_idx = i;
    for (int i = 0; i < N; i++) if (access_way[i]) aw = i;
    if (req_valid) begin
      if (free_idx >= 0) begin
        wp = free_idx; wr = free_idx;
      end else begin
        wp = model_victim(ri);
        wr = rr_ptr[ri];
        rr_ptr[ri] = (rr_ptr[ri] + 1) % N;
      end
    end
    if (access_valid && aw >= 0) model_touch(int'(access_index), aw);
    if (req_valid) model_touch(ri, wp);
    exp_valid = req_valid;
    if (req_valid) begin
      exp_way_p = N'(1 << wp); exp_enc_p = L'(wp);
      exp_way_r = N'(1 << wr); exp_enc_r = L'(wr);
      exp_empty = (free_idx >= 0);
    end
  endtask

  task automatic idle();
    req_valid = 1'b0; req_index = '0; ways_in_use = '0;
    access_valid = 1'b0; access_index = '0; access_way = '0;
  endtask

  task automatic drive(input logic rv, input int ri, input logic [N-1:0] wiu,
                       input logic av, input int ai, input logic [N-1:0] aw);
    req_valid = rv; req_index = IB'(ri); ways_in_use = wiu;
    access_valid = av; access_index = IB'(ai); access_way = aw;
  endtask

  task automatic cycle();
    @(posedge clock);
    if (!reset) model_step();
    #1;
  endtask

  always @(negedge clock) begin
    if (run_cmp) begin
      chk("p_valid", p_valid, exp_valid);
      chk("p_way",   p_way,   exp_way_p);
      chk("p_enc",   p_enc,   exp_enc_p);
      chk("p_empty", p_empty, exp_empty);
      chk("r_valid", r_valid, exp_valid);
      chk("r_way",   r_way,   exp_way_r);
      chk("r_enc",   r_enc,   exp_enc_r);
      chk("r_empty", r_empty, exp_empty);
    end
  end

  initial begin
    int seq_p [4];
    int seq_r [5];
    logic [N-1:0] wiu, aw;
    seq_p = '{1, 4, 2, 8};
    seq_r = '{1, 2, 4, 8, 1};

    reset = 1'b1;
    idle();
    model_clear();
    run_cmp = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("reset_valid", p_valid, 0);
    chk("reset_way", p_way, 0);

    drive(1, 5, 4'b1011, 0, 0, 4'b0000); cycle();
    chk("empty_valid", p_valid, 1);
    chk("empty_way", p_way, 4'b0100);
    chk("empty_enc", p_enc, 2);
    chk("empty_flag", p_empty, 1);
    idle(); cycle();

    for (int k = 0; k < 4; k++) begin
      drive(1, 3, 4'b1111, 0, 0, 4'b0000); cycle();
      chk("plru_seq_way", p_way, seq_p[k]);
      chk("plru_seq_empty", p_empty, 0);
    end
    idle(); cycle();

    drive(0, 0, 4'b0000, 1, 7, 4'b0001); cycle();
    drive(1, 7, 4'b1111, 0, 0, 4'b0000); cycle();
    chk("hit_way", p_way, 4'b0100);
    drive(1, 8, 4'b1111, 0, 0, 4'b0000); cycle();
    chk("other_set_way", p_way, 4'b0001);

    drive(1, 2, 4'b1111, 1, 2, 4'b0100); cycle();
    chk("collide_way", p_way, 4'b0001);
    drive(1, 2, 4'b1111, 0, 0, 4'b0000); cycle();
    chk("collide_next_way", p_way, 4'b1000);

    drive(1, 1, 4'b1111, 0, 0, 4'b0000); cycle();
    reset = 1'b1;
    idle();
    model_clear();
    #1;
    chk("midreset_valid", p_valid, 0);
    chk("midreset_way", p_way, 0);
    @(posedge clock); @(posedge clock);
    #1 reset = 1'b0;
    cycle();
    chk("post_release_valid", p_valid, 0);
    drive(1, 1, 4'b1111, 0, 0, 4'b0000); cycle();
    chk("post_reset_way", p_way, 4'b0001);
    idle(); cycle();

    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 4'b1111, 1, 0, N'(1 << (k % N))); cycle();
      chk("rr_seq_way", r_way, seq_r[k]);
      drive(0, 0, 4'b0000, 1, 0, 4'b0010); cycle();
    end
    drive(1, 0, 4'b0111, 0, 0, 4'b0000); cycle();
    chk("rr_empty_way", r_way, 4'b1000);
    chk("rr_empty_flag", r_empty, 1);
    drive(1, 0, 4'b1111, 0, 0, 4'b0000); cycle();
    chk("rr_no_advance_way", r_way, 4'b0010);
    idle(); cycle();

    for (int c = 0; c < 3000; c++) begin
      wiu = ($urandom_range(0, 1) == 1) ? 4'b1111 : N'($urandom);
      case ($urandom_range(0, 4))
        0: aw = 4'b0000;
        1: aw = 4'b0001;
        2: aw = 4'b0010;
        3: aw = 4'b0100;
        default: aw = 4'b1000;
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), wiu,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3), aw);
      cycle();
    end
    idle(); cycle(); cycle();
    run_cmp = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
